mac_sequencer: RTL

- Controller that sequences one pipelined load-enabled MAC unit (multiply_acc) to compute C = A x B, where A is ROWS x INNER and B is INNER x COLS.
- Reads A and B from external synchronous RAMs (1-cycle read latency) and streams one operand pair per cycle into the MAC.
- Drives the MAC load strobe aligned to the MAC pipeline and writes each finished dot product to a C RAM write port.
- Sits between the matrix buffers and the MAC datapath.

---
 rtl/mac_seq_pkg.sv | 18 +
 rtl/mac_seq_dly.sv | 26 ++
 rtl/mac_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared constants for the MAC sequencer: FSM encodings, pipeline alignment
// delays and the address-width helper.
package mac_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Issue-to-load and issue-to-write distances through RAM + MAC pipeline
   localparam int LOAD_DLY = 3;
   localparam int WR_DLY   = 4;

   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mac_seq_dly.sv
// Shift-register delay line with asynchronous active-low clear; carries
// issue-side tags forward to the MAC load and C write cycles.
module mac_seq_dly #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_p [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
      end else begin
         stage_p[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
   end

   assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one pipelined MAC through C = A x B, streaming one operand pair per
// cycle from the A/B RAMs. Optional macro MAC_SEQ_PERF_EN adds perf counters.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int INNER      = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              a_rd_en,
   output logic [addr_w(ROWS*INNER)-1:0]     a_rd_addr,
   input  logic [DATA_WIDTH-1:0]             a_rd_data,
   output logic                              b_rd_en,
   output logic [addr_w(INNER*COLS)-1:0]     b_rd_addr,
   input  logic [DATA_WIDTH-1:0]             b_rd_data,
   output logic [DATA_WIDTH-1:0]             mac_a,
   output logic [DATA_WIDTH-1:0]             mac_b,
   output logic                              mac_load,
   input  logic [DATA_WIDTH-1:0]             mac_acc,
   output logic                              c_wr_en,
   output logic [addr_w(ROWS*COLS)-1:0]      c_wr_addr,
`ifdef MAC_SEQ_PERF_EN
   output logic [31:0]                       perf_cycles,
   output logic [15:0]                       perf_runs,
`endif
   output logic [DATA_WIDTH-1:0]             c_wr_data
);

   localparam int A_AW = addr_w(ROWS*INNER);
   localparam int B_AW = addr_w(INNER*COLS);
   localparam int C_AW = addr_w(ROWS*COLS);
   localparam int KW   = addr_w(INNER);
   localparam int CW   = addr_w(COLS);
   localparam int RW   = addr_w(ROWS);

   logic [1:0]      state;
   logic [KW-1:0]   k;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic [A_AW-1:0] a_addr;
   logic [A_AW-1:0] a_row_base;
   logic [B_AW-1:0] b_addr;
   logic [C_AW-1:0] c_addr;
   logic [2:0]      drain_cnt;
   logic            issue;
   logic            k_wrap;
   logic            col_wrap;
   logic            row_wrap;
   logic            first_iss;
   logic            last_iss;

   assign issue     = (state == ST_RUN);
   assign k_wrap    = (k == KW'(INNER-1));
   assign col_wrap  = (col == CW'(COLS-1));
   assign row_wrap  = (row == RW'(ROWS-1));
   assign first_iss = issue && (k == '0);
   assign last_iss  = issue && k_wrap;

   // Addresses advance from running bases so no multiplier is needed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         k          <= '0;
         col        <= '0;
         row        <= '0;
         a_addr     <= '0;
         a_row_base <= '0;
         b_addr     <= '0;
         c_addr     <= '0;
         drain_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE:  if (start) state <= ST_RUN;
            ST_RUN:   if (k_wrap && col_wrap && row_wrap) begin
                         state     <= ST_DRAIN;
                         drain_cnt <= 3'(WR_DLY);
                      end
            ST_DRAIN: if (drain_cnt == 3'd0) state <= ST_DONE;
                      else drain_cnt <= drain_cnt - 3'd1;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         if (issue) begin
            if (!k_wrap) begin
               k      <= k + KW'(1);
               a_addr <= a_addr + A_AW'(1);
               b_addr <= b_addr + B_AW'(COLS);
            end else begin
               k      <= '0;
               c_addr <= (col_wrap && row_wrap) ? '0 : c_addr + C_AW'(1);
               if (!col_wrap) begin
                  col    <= col + CW'(1);
                  a_addr <= a_row_base;
                  b_addr <= B_AW'(col) + B_AW'(1);
               end else begin
                  col    <= '0;
                  b_addr <= '0;
                  if (!row_wrap) begin
                     row        <= row + RW'(1);
                     a_row_base <= a_row_base + A_AW'(INNER);
                     a_addr     <= a_row_base + A_AW'(INNER);
                  end else begin
                     row        <= '0;
                     a_row_base <= '0;
                     a_addr     <= '0;
                  end
               end
            end
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign a_rd_en   = issue;
   assign b_rd_en   = issue;
   assign a_rd_addr = a_addr;
   assign b_rd_addr = b_addr;
   assign mac_a     = a_rd_data;
   assign mac_b     = b_rd_data;
   assign c_wr_data = mac_acc;

   mac_seq_dly #(.WIDTH(1), .DEPTH(LOAD_DLY)) u_first_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (first_iss),
      .dout    (mac_load)
   );

   mac_seq_dly #(.WIDTH(1), .DEPTH(WR_DLY)) u_last_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (last_iss),
      .dout    (c_wr_en)
   );

   mac_seq_dly #(.WIDTH(C_AW), .DEPTH(WR_DLY)) u_caddr_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (c_addr),
      .dout    (c_wr_addr)
   );

`ifdef MAC_SEQ_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles <= '0;
         perf_runs   <= '0;
      end else begin
         if (state == ST_IDLE && start) perf_cycles <= '0;
         else if (busy)                 perf_cycles <= perf_cycles + 32'd1;
         if (done) perf_runs <= perf_runs + 16'd1;
      end
   end
`endif

endmodule
